// File: rtl/if_stage_if.sv
// if_stage_if -- fetch request bus between the IF stage and the memory controller.
//   mc_req  : fetch request (IF stage -> controller)
//   mc_addr : word address of the request (IF stage -> controller)
//   mc_done : one-cycle completion pulse (controller -> IF stage)
//   mc_data : fetched word, valid with mc_done (controller -> IF stage)
// The master modport is the IF stage; the slave modport is the controller.
interface if_stage_if;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    modport master (output mc_req, mc_addr, input mc_done, mc_data);
    modport slave  (input mc_req, mc_addr, output mc_done, mc_data);
endinterface

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage.
// Fetches one word at a time from the memory controller and presents it to
// the IF/ID register. It handles downstream stalls, EX redirects (including
// redirects that arrive mid-fetch), and a global freeze via rdy_in.
// Ports:
//   clk_in   : clock, all state on rising edge
//   rst_in   : asynchronous active-low reset
//   rdy_in   : chip ready; low freezes every register
//   stall    : downstream stall; the presented instruction is not consumed
//   jump_en  : one-cycle redirect pulse, jump_pc is the target
//   mc       : memory-controller fetch bus (master side)
//   if_pc    : PC toward IF/ID
//   if_ins   : instruction toward IF/ID
//   if_valid : if_pc/if_ins hold a real fetched instruction
module if_stage #(
    parameter logic [31:0] NOP_INS  = 32'h00000013,
    parameter logic [31:0] NOP_PC   = 32'h00000000,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [31:0]        jump_pc,
    if_stage_if.master         mc,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_ins,
    output logic               if_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            mc.mc_req  <= 1'b0;
            mc.mc_addr <= 32'h0;
            if_pc      <= NOP_PC;
            if_ins     <= NOP_INS;
            if_valid   <= 1'b0;
        end else if (rdy_in) begin
            // A redirect always kills whatever is presented, stalled or not.
            if (jump_en) begin
                pc       <= {jump_pc[31:2], 2'b00};
                if_pc    <= NOP_PC;
                if_ins   <= NOP_INS;
                if_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // Without a redirect, issue when nothing is presented or
                    // the presented word is consumed this edge.
                    if (!jump_en && (!if_valid || !stall)) begin
                        if_pc      <= NOP_PC;
                        if_ins     <= NOP_INS;
                        if_valid   <= 1'b0;
                        mc.mc_req  <= 1'b1;
                        mc.mc_addr <= pc;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (jump_en) begin
                        // The outstanding fetch still has to complete; its
                        // data is dropped in FLUSH unless it finishes now.
                        if (mc.mc_done) begin
                            mc.mc_req <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (mc.mc_done) begin
                        mc.mc_req <= 1'b0;
                        if_pc     <= pc;
                        if_ins    <= mc.mc_data;
                        if_valid  <= 1'b1;
                        pc        <= pc + 32'd4;
                        state     <= IDLE;
                    end
                end
                FLUSH: begin
                    if (mc.mc_done) begin
                        mc.mc_req <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter NOP_INS, default 32'h00000013, the bubble instruction (addi x0,x0,0) driven when no fetched instruction is presented.
REQ-002 SHALL have parameter NOP_PC, default 32'h00000000, the PC driven with a bubble.
REQ-003 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address.
REQ-004 SHALL have port clk_in input 1: the single clock, all state on rising edge.
REQ-005 SHALL have port rst_in input 1: asynchronous, active-low reset.
REQ-006 SHALL have port rdy_in input 1: chip ready; low freezes the block.
REQ-007 SHALL have port stall input 1: downstream chip stall; presented instruction not consumed.
REQ-008 SHALL have port jump_en input 1: one-cycle redirect pulse from EX.
REQ-009 SHALL have port jump_pc input 32: redirect target, valid with jump_en.
REQ-010 SHALL have port mc_req output 1: fetch request to memory controller.
REQ-011 SHALL have port mc_addr output 32: word address of request.
REQ-012 SHALL have port mc_done input 1: one-cycle completion pulse.
REQ-013 SHALL have port mc_data input 32: fetched word, valid with mc_done.
REQ-014 SHALL have port if_pc output 32: PC toward IF/ID register.
REQ-015 SHALL have port if_ins output 32: instruction toward IF/ID register.
REQ-016 SHALL have port if_valid output 1: if_pc/if_ins carry a real fetched instruction.

Function
REQ-017 SHALL implement states IDLE, BUSY, FLUSH; all outputs registered.
REQ-018 IDLE, if_valid=0, rdy_in=1, no jump: SHALL at the edge set mc_req=1, mc_addr=pc, go BUSY.
REQ-019 IDLE, if_valid=1: SHALL issue no request until consumed; consumption = edge with rdy_in=1, stall=0.
REQ-020 On consumption: SHALL load if_pc=NOP_PC, if_ins=NOP_INS, if_valid=0, and at the same edge issue the next request per REQ-018 (no idle cycle).
REQ-021 BUSY: mc_req and mc_addr SHALL stay stable until mc_done sampled high.
REQ-022 BUSY with mc_done, no jump: SHALL set mc_req=0, if_pc=pc, if_ins=mc_data, if_valid=1, pc=pc+4 (mod 2^32), go IDLE.
REQ-023 While if_valid=1 and stall=1: if_pc/if_ins/if_valid SHALL hold unchanged.
REQ-024 jump_en=1 (rdy_in=1): SHALL set pc=jump_pc with bits[1:0] forced 0, drop if_valid, drive bubble outputs; applies regardless of stall.
REQ-025 Jump in IDLE: SHALL stay IDLE; next request uses new pc.
REQ-026 Jump in BUSY without mc_done: SHALL go FLUSH, keep mc_req high until mc_done, discard that mc_data, then go IDLE with mc_req=0.
REQ-027 Jump coinciding with mc_done in BUSY: jump wins; mc_data SHALL be discarded, mc_req=0, go IDLE, pc unchanged by +4.
REQ-028 Jump in FLUSH: SHALL update pc and remain FLUSH.
REQ-029 rdy_in=0: all state and outputs SHALL be frozen; jump_en, stall, mc_done ignored.
REQ-030 if_valid SHALL never be 1 while if_ins holds data from a discarded fetch.

Reset
REQ-031 rst_in=0 SHALL immediately force state IDLE, pc=RESET_PC, mc_req=0, mc_addr=0, if_pc=NOP_PC, if_ins=NOP_INS, if_valid=0, including mid-BUSY/FLUSH.
REQ-032 After release, first mc_req SHALL assert at the first rising edge with rst_in=1, rdy_in=1.

Verification
REQ-033 Basic fetch: release reset, mc_done 3 cycles after mc_req with 32'h00500093 -> mc_addr 0; then if_pc 0, if_ins 32'h00500093, if_valid 1 for one cycle; same edge mc_addr 4.
REQ-034 Stall hold: stall=1 five cycles while if_valid=1 -> outputs held, mc_req 0 throughout; stall drop -> bubble next cycle, mc_addr 8.
REQ-035 Jump mid-fetch: jump_en, jump_pc 32'h00000103 while BUSY on addr 4 -> outputs NOP, returned word discarded, next mc_addr 32'h00000100.
REQ-036 Jump same cycle as mc_done -> if_valid stays 0, no mc_addr 8 request, next mc_addr = jump target.
REQ-037 Reset mid-BUSY: rst_in low asynchronously -> mc_req 0, if_ins 32'h00000013 before next edge; after release mc_addr 0.
REQ-038 Freeze: rdy_in low 4 cycles with mc_done and jump_en pulsed -> no state or output change; resume continues prior fetch.
